// File: rtl/req_queue_pkg.sv
// Shared constants for the two-channel request queue: grant encodings and channel indices.
package req_queue_pkg;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CH0  = 2'b01;
    localparam logic [1:0] GNT_CH1  = 2'b10;
    localparam logic [1:0] GNT_BOTH = 2'b11;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;
endpackage

// File: rtl/req_queue_2ch_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an explicit occupancy counter.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/req_queue_2ch.sv
// Two-channel request queue: per-channel FIFOs feed an arbiter via req, and the
// granted head is popped into one registered output slot tagged with its source.
module req_queue_2ch
    import req_queue_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    output logic [1:0]        req,
    input  logic [1:0]        grant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1
);
    logic              full0, full1, empty0, empty1;
    logic [DATA_W-1:0] head0, head1;
    logic              push0, push1, pop0, pop1, slot_free;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;

    // Ready depends only on stored occupancy (and rst), never on grant/out_ready.
    assign in0_ready = !rst && !full0;
    assign in1_ready = !rst && !full1;
    assign push0     = in0_valid && in0_ready;
    assign push1     = in1_valid && in1_ready;

    assign slot_free = !out_valid_q || out_ready;
    assign req[0]    = !rst && !empty0 && slot_free;
    assign req[1]    = !rst && !empty1 && slot_free;

    // Stale or double grants simply fail to match and are ignored.
    assign pop0 = (grant == GNT_CH0) && req[0];
    assign pop1 = (grant == GNT_CH1) && req[1];

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .wr_data(in0_data), .pop(pop0),
        .rd_data(head0), .full(full0), .empty(empty0), .count(count0)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .wr_data(in1_data), .pop(pop1),
        .rd_data(head1), .full(full1), .empty(empty1), .count(count1)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (pop0) begin
            out_valid_d = 1'b1;
            out_data_d  = head0;
            out_src_d   = CH0;
        end else if (pop1) begin
            out_valid_d = 1'b1;
            out_data_d  = head1;
            out_src_d   = CH1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
endmodule

// File: doc/req_queue_2ch.md
Name: req_queue_2ch

Overview:
Upstream request-queueing stage for the 2-requester arbiter.
- Buffers transactions from two independent sources in per-channel FIFOs.
- Drives the arbiter's 2-bit req vector from FIFO occupancy.
- On the arbiter's grant, pops the granted channel's head into a single registered output slot with valid/ready handshake, tagged with its source.

Parameters:
DATA_W, 8, payload width per transaction
DEPTH, 4, entries per channel FIFO; power of 2, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in0_valid  input  1  channel 0 push request
in0_ready  output  1  channel 0 FIFO can accept
in0_data  input  DATA_W  channel 0 payload
in1_valid  input  1  channel 1 push request
in1_ready  output  1  channel 1 FIFO can accept
in1_data  input  DATA_W  channel 1 payload
req  output  2  to arbiter; bit i = channel i has a poppable head
grant  input  2  from arbiter; 01 = ch0, 10 = ch1, 00/11 = none
out_valid  output  1  output slot holds a transaction
out_ready  input  1  downstream accepts output slot
out_data  output  DATA_W  granted payload
out_src  output  1  source channel of out_data (0/1)
count0  output  CNT_W  channel 0 occupancy
count1  output  CNT_W  channel 1 occupancy

Behaviour:
Reset:
- While rst is high: FIFO pointers/counts = 0, out_valid = 0, out_data = 0, out_src = 0, req = 00.
- in0_ready/in1_ready = 0 while rst is high; 1 from the first cycle after release.
- Reset mid-operation discards all queued and output-slot contents; no partial pop or push completes.

Push:
- Channel i pushes when ini_valid && ini_ready at the clock edge.
- ini_ready = (counti != DEPTH); registered state only, no comb path from grant or out_ready.
- A push into a full FIFO cannot occur.
- Data written at write pointer; pointer wraps DEPTH-1 -> 0.

Request generation (combinational):
- slot_free = !out_valid || out_ready.
- req[i] = (counti != 0) && slot_free.

Pop:
- pop0 = grant == 01 && req[0].
- pop1 = grant == 10 && req[1].
- grant 11 and grant 00: no pop.
- grant[i] while req[i] = 0 is silently ignored; stale grants are legal.
- At most one pop per cycle.
- On pop, the next cycle gives: out_valid = 1, out_data = FIFO i head, out_src = i, read pointer i advances with wrap, counti decrements.
- Latency: push-to-req = 1 cycle; grant-to-out_valid = 1 cycle.

Output slot:
- out_valid/out_data/out_src hold stable until out_valid && out_ready.
- Handshake without a new pop in the same cycle: out_valid -> 0 next cycle.
- Handshake with a new pop in the same cycle: slot reloads back-to-back, out_valid stays 1.
- Throughput: 1 transaction/cycle.

Simultaneous events:
- Push and pop on the same channel in the same cycle: count unchanged, both pointers advance.
- Push into an empty FIFO cannot pop in the same cycle (req was 0).
- Full FIFO popped: ini_ready rises the following cycle, not combinationally.

Counts: counti in [0, DEPTH]; overflow and underflow are unreachable by construction and asserted in the bench.

Decomposition:
- Package req_queue_pkg: grant encoding constants GNT_NONE = 2'b00, GNT_CH0 = 2'b01, GNT_CH1 = 2'b10, GNT_BOTH = 2'b11; channel index constants CH0 = 0, CH1 = 1.
- Sub-module sync_fifo (DATA_W, DEPTH), instantiated twice: push/pop/full/empty/count, wrap-around pointers.
- Top holds req generation, pop decode and output slot.

Test Plan:
- Reset, then idle: rst 1 for 2 cycles -> out_valid = 0, req = 00, in*_ready = 0 during reset and 1 on the first cycle after; counts 0.
- Single-channel ordering: push 0x11, 0x22, 0x33 on ch0; hold grant = 01, out_ready = 1 -> req[0] = 1 one cycle after the first push; outputs 0x11, 0x22, 0x33 in order, out_src = 0, back-to-back, count0 returns to 0, req = 00.
- Full/wrap: DEPTH = 4, push 0xA0..0xA3 on ch1 -> in1_ready = 0, count1 = 4; pop one with grant = 10 -> in1_ready = 1 next cycle; push 0xA4 then drain -> 0xA1..0xA4 in order, write pointer wrapped.
- Illegal/stale grant: both FIFOs non-empty, grant = 11 for 3 cycles -> no out_valid, counts unchanged; grant = 01 with ch0 empty -> no pop.
- Backpressure: out_valid = 1 with 0x5A, out_ready = 0 for 4 cycles -> out_data held, req = 00 despite non-empty FIFOs; out_ready = 1 with grant = 10 -> same-cycle reload with ch1 head, out_src = 1.
- Reset mid-operation: count0 = 3, out_valid = 1, assert rst for one cycle -> next cycle counts 0, out_valid = 0, req = 00; a subsequent push/pop returns only the new data.
